// File: rtl/cpci_intr_ctrl_pkg.sv
// Shared definitions for the CPCI interrupt controller: status bit positions,
// bit-class masks and register-bus addresses.
package cpci_intr_defines;

    localparam int INTR_INGRESS_DONE    = 31;
    localparam int INTR_EGRESS_DONE     = 30;
    localparam int INTR_PHY             = 29;
    localparam int INTR_PKT_AVAIL       = 8;
    localparam int INTR_CNET_ERR        = 5;
    localparam int INTR_CNET_RD_TIMEOUT = 4;
    localparam int INTR_CNET_PROG_ERR   = 3;
    localparam int INTR_DMA_TIMEOUT     = 2;
    localparam int INTR_DMA_XFER_ERR    = 1;
    localparam int INTR_DMA_FATAL       = 0;

    localparam logic [31:0] STICKY_MASK = 32'hC000_003F;
    localparam logic [31:0] LEVEL_MASK  = 32'h2000_0100;

    localparam logic [1:0] ADDR_STATUS     = 2'd0;
    localparam logic [1:0] ADDR_MASK       = 2'd1;
    localparam logic [1:0] ADDR_STATUS_RAW = 2'd2;
    localparam logic [1:0] ADDR_FORCE      = 2'd3;

endpackage

// File: rtl/cpci_intr_ctrl_holdoff.sv
// Loadable saturating down-counter; busy while non-zero. Used to keep INTA
// deasserted for a short window after the host clears status.
module cpci_intr_holdoff #(
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic load,
    output logic busy
);

    localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLDOFF_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/cpci_intr_ctrl.sv
// CPCI interrupt status/mask controller driving the active-low PCI INTA line,
// with read-to-clear status, host mask and post-read holdoff.
module cpci_intr_ctrl
    import cpci_intr_defines::*;
#(
    parameter int          HOLDOFF_CYCLES = 4,
    parameter logic [31:0] MASK_RESET     = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        reg_rd_req,
    input  logic        reg_wr_req,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wr_data,
    output logic [31:0] reg_rd_data,
    output logic        reg_ack,
    input  logic        ev_ingress_done,
    input  logic        ev_egress_done,
    input  logic        ev_cnet_err,
    input  logic        ev_cnet_rd_timeout,
    input  logic        ev_cnet_prog_err,
    input  logic        ev_dma_timeout,
    input  logic        ev_dma_xfer_err,
    input  logic        ev_dma_fatal,
    input  logic        lvl_phy_int,
    input  logic        lvl_pkt_avail,
    output logic        INTR_A_N
);

    logic [31:0] sticky;
    logic [31:0] level;
    logic [31:0] mask;
    logic [31:0] events;
    logic [31:0] level_next;
    logic [31:0] effective;
    logic [31:0] pending;
    logic [31:0] captured;
    logic [31:0] sticky_next;
    logic [31:0] rd_value;
    logic        rd_only;
    logic        status_clear;
    logic        holdoff_busy;

    always_comb begin
        events                       = '0;
        events[INTR_INGRESS_DONE]    = ev_ingress_done;
        events[INTR_EGRESS_DONE]     = ev_egress_done;
        events[INTR_CNET_ERR]        = ev_cnet_err;
        events[INTR_CNET_RD_TIMEOUT] = ev_cnet_rd_timeout;
        events[INTR_CNET_PROG_ERR]   = ev_cnet_prog_err;
        events[INTR_DMA_TIMEOUT]     = ev_dma_timeout;
        events[INTR_DMA_XFER_ERR]    = ev_dma_xfer_err;
        events[INTR_DMA_FATAL]       = ev_dma_fatal;

        level_next                 = '0;
        level_next[INTR_PHY]       = lvl_phy_int;
        level_next[INTR_PKT_AVAIL] = lvl_pkt_avail;
    end

    // A simultaneous write takes the slot, so only a lone read may clear status.
    always_comb begin
        effective    = sticky | level;
        pending      = effective & ~mask;
        rd_only      = reg_rd_req & ~reg_wr_req;
        status_clear = rd_only && (reg_addr == ADDR_STATUS);
        captured     = status_clear ? (effective & STICKY_MASK) : '0;
        sticky_next  = (sticky & ~captured) | events;
        if (reg_wr_req && (reg_addr == ADDR_FORCE)) begin
            sticky_next = sticky_next | (reg_wr_data & STICKY_MASK);
        end

        rd_value = '0;
        case (reg_addr)
            ADDR_STATUS,
            ADDR_STATUS_RAW: rd_value = effective;
            ADDR_MASK:       rd_value = mask;
            default:         rd_value = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sticky      <= '0;
            level       <= '0;
            mask        <= MASK_RESET;
            reg_ack     <= 1'b0;
            reg_rd_data <= '0;
            INTR_A_N    <= 1'b1;
        end else begin
            sticky   <= sticky_next;
            level    <= level_next;
            reg_ack  <= reg_rd_req | reg_wr_req;
            INTR_A_N <= holdoff_busy ? 1'b1 : ~(|pending);
            if (reg_wr_req && (reg_addr == ADDR_MASK)) begin
                mask <= reg_wr_data;
            end
            if (rd_only) begin
                reg_rd_data <= rd_value;
            end
        end
    end

    cpci_intr_holdoff #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .CLK  (CLK),
        .RST_N(RST_N),
        .load (status_clear),
        .busy (holdoff_busy)
    );

endmodule

// File: tb/tb_cpci_intr_ctrl.sv
// Self-checking bench for cpci_intr_ctrl: table-driven register accesses with a
// read-data scoreboard, plus hand-timed INTA latency and holdoff sequences.
module tb_cpci_intr_ctrl;
    import cpci_intr_defines::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        reg_rd_req;
    logic        reg_wr_req;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_rd_data;
    logic        reg_ack;
    logic        ev_ingress_done;
    logic        ev_egress_done;
    logic        ev_cnet_err;
    logic        ev_cnet_rd_timeout;
    logic        ev_cnet_prog_err;
    logic        ev_dma_timeout;
    logic        ev_dma_xfer_err;
    logic        ev_dma_fatal;
    logic        lvl_phy_int;
    logic        lvl_pkt_avail;
    logic        INTR_A_N;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    typedef struct {
        logic [1:0]  addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    sb_entry_t sb[$];
    vec_t      tbl[$];
    int        checks = 0;
    int        errors = 0;

    always #5 CLK = ~CLK;

    cpci_intr_ctrl #(
        .HOLDOFF_CYCLES(4),
        .MASK_RESET    (32'h0000_0000)
    ) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .reg_rd_req        (reg_rd_req),
        .reg_wr_req        (reg_wr_req),
        .reg_addr          (reg_addr),
        .reg_wr_data       (reg_wr_data),
        .reg_rd_data       (reg_rd_data),
        .reg_ack           (reg_ack),
        .ev_ingress_done   (ev_ingress_done),
        .ev_egress_done    (ev_egress_done),
        .ev_cnet_err       (ev_cnet_err),
        .ev_cnet_rd_timeout(ev_cnet_rd_timeout),
        .ev_cnet_prog_err  (ev_cnet_prog_err),
        .ev_dma_timeout    (ev_dma_timeout),
        .ev_dma_xfer_err   (ev_dma_xfer_err),
        .ev_dma_fatal      (ev_dma_fatal),
        .lvl_phy_int       (lvl_phy_int),
        .lvl_pkt_avail     (lvl_pkt_avail),
        .INTR_A_N          (INTR_A_N)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkRd(input logic [1:0] addr, input logic [31:0] exp, input string name);
        vec_t v;
        v.addr = addr; v.rd = 1'b1; v.wr = 1'b0; v.wdata = '0;
        v.chk = 1'b1; v.exp = exp; v.name = name;
        return v;
    endfunction

    function automatic vec_t mkWr(input logic [1:0] addr, input logic [31:0] data, input string name);
        vec_t v;
        v.addr = addr; v.rd = 1'b0; v.wr = 1'b1; v.wdata = data;
        v.chk = 1'b0; v.exp = '0; v.name = name;
        return v;
    endfunction

    function automatic vec_t mkRdWr(input logic [1:0] addr, input logic [31:0] data,
                                    input logic [31:0] held, input string name);
        vec_t v;
        v.addr = addr; v.rd = 1'b1; v.wr = 1'b1; v.wdata = data;
        v.chk = 1'b1; v.exp = held; v.name = name;
        return v;
    endfunction

    // Drives one request for a single edge and queues the ack it must produce.
    task automatic applyStimulus(input vec_t v);
        sb_entry_t e;
        if (RST_N && (v.rd || v.wr)) begin
            e.chk  = v.chk;
            e.exp  = v.exp;
            e.name = v.name;
            sb.push_back(e);
        end
        reg_addr    = v.addr;
        reg_rd_req  = v.rd;
        reg_wr_req  = v.wr;
        reg_wr_data = v.wdata;
        tick();
        reg_rd_req  = 1'b0;
        reg_wr_req  = 1'b0;
        reg_wr_data = '0;
    endtask

    always @(negedge CLK) begin : monitor
        sb_entry_t e;
        if (reg_ack === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ack actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                if (e.chk) checkOutput(e.name, reg_rd_data, e.exp);
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        reg_rd_req = 1'b0; reg_wr_req = 1'b0; reg_addr = '0; reg_wr_data = '0;
        ev_ingress_done = 1'b0; ev_egress_done = 1'b0;
        ev_cnet_err = 1'b0; ev_cnet_rd_timeout = 1'b0; ev_cnet_prog_err = 1'b0;
        ev_dma_timeout = 1'b0; ev_dma_xfer_err = 1'b0; ev_dma_fatal = 1'b0;
        lvl_phy_int = 1'b0; lvl_pkt_avail = 1'b0;

        repeat (3) tick();
        checkOutput("rst_intr", 32'(INTR_A_N), 32'd1);
        checkOutput("rst_ack", 32'(reg_ack), 32'd0);
        checkOutput("rst_rd_data", reg_rd_data, 32'd0);
        RST_N = 1'b1;
        tick();

        tbl.delete();
        tbl.push_back(mkRd(ADDR_MASK,       32'h0000_0000, "rst_mask"));
        tbl.push_back(mkRd(ADDR_STATUS,     32'h0000_0000, "rst_status"));
        tbl.push_back(mkRd(ADDR_STATUS_RAW, 32'h0000_0000, "rst_raw"));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput("idle_intr", 32'(INTR_A_N), 32'd1);
        end
        repeat (8) tick();

        // Event pulse to INTA low takes two edges; the clearing read then holds INTA off.
        ev_ingress_done = 1'b1;
        tick();
        ev_ingress_done = 1'b0;
        checkOutput("a_intr_lat1", 32'(INTR_A_N), 32'd1);
        tick();
        checkOutput("a_intr_lat2", 32'(INTR_A_N), 32'd0);
        applyStimulus(mkRd(ADDR_STATUS,     32'h8000_0000, "a_status"));
        applyStimulus(mkRd(ADDR_STATUS_RAW, 32'h0000_0000, "a_raw_cleared"));
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("a_holdoff_intr", 32'(INTR_A_N), 32'd1);
        end

        applyStimulus(mkWr(ADDR_MASK, 32'h0000_0100, "b_mask_wr"));
        lvl_pkt_avail = 1'b1;
        repeat (4) tick();
        checkOutput("b_masked_intr", 32'(INTR_A_N), 32'd1);
        applyStimulus(mkRd(ADDR_STATUS, 32'h0000_0100, "b_status_lvl"));
        repeat (6) tick();
        applyStimulus(mkWr(ADDR_MASK, 32'h0000_0000, "b_unmask"));
        checkOutput("b_unmask_lat1", 32'(INTR_A_N), 32'd1);
        tick();
        checkOutput("b_unmask_lat2", 32'(INTR_A_N), 32'd0);
        applyStimulus(mkRd(ADDR_STATUS,     32'h0000_0100, "b_status_lvl_kept"));
        applyStimulus(mkRd(ADDR_STATUS_RAW, 32'h0000_0100, "b_raw_lvl_kept"));
        lvl_pkt_avail = 1'b0;
        repeat (8) tick();

        // Event landing on the same edge as a clearing read must survive.
        ev_ingress_done = 1'b1;
        tick();
        ev_ingress_done = 1'b0;
        repeat (2) tick();
        ev_dma_fatal = 1'b1;
        applyStimulus(mkRd(ADDR_STATUS, 32'h8000_0000, "c_status_capture"));
        ev_dma_fatal = 1'b0;
        applyStimulus(mkRd(ADDR_STATUS, 32'h0000_0001, "c_status_event_survives"));

        ev_egress_done = 1'b1;
        tick();
        ev_egress_done = 1'b0;
        checkOutput("d_holdoff_1", 32'(INTR_A_N), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("d_holdoff_n", 32'(INTR_A_N), 32'd1);
        end
        tick();
        checkOutput("d_holdoff_expire", 32'(INTR_A_N), 32'd0);
        applyStimulus(mkRd(ADDR_STATUS_RAW, 32'h4000_0000, "d_raw_kept"));
        applyStimulus(mkRd(ADDR_STATUS,     32'h4000_0000, "d_status_kept"));
        repeat (8) tick();

        tbl.delete();
        tbl.push_back(mkWr(ADDR_FORCE,      32'hFFFF_FFFF, "e_force"));
        tbl.push_back(mkRd(ADDR_STATUS_RAW, 32'hC000_003F, "e_raw_force"));
        tbl.push_back(mkRd(ADDR_STATUS,     32'hC000_003F, "e_status_force"));
        tbl.push_back(mkRd(ADDR_STATUS_RAW, 32'h0000_0000, "e_raw_after_clear"));
        tbl.push_back(mkRdWr(ADDR_MASK, 32'hA5A5_5A5A, 32'h0000_0000, "e_rdwr_rd_data_held"));
        tbl.push_back(mkRd(ADDR_MASK,       32'hA5A5_5A5A, "e_mask_rb"));
        tbl.push_back(mkWr(ADDR_STATUS,     32'hFFFF_FFFF, "e_status_wr_ignored"));
        tbl.push_back(mkRd(ADDR_STATUS_RAW, 32'h0000_0000, "e_raw_after_status_wr"));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
        end
        repeat (2) tick();

        // Reset arriving together with a request: no ack, everything back to reset values.
        applyStimulus(mkWr(ADDR_FORCE, 32'h0000_003F, "f_force"));
        repeat (2) tick();
        checkOutput("f_pre_rst_intr", 32'(INTR_A_N), 32'd0);
        RST_N = 1'b0;
        applyStimulus(mkRd(ADDR_STATUS, 32'h0000_0000, "f_rd_in_rst"));
        checkOutput("f_rst_ack", 32'(reg_ack), 32'd0);
        checkOutput("f_rst_intr", 32'(INTR_A_N), 32'd1);
        RST_N = 1'b1;
        applyStimulus(mkRd(ADDR_STATUS_RAW, 32'h0000_0000, "f_raw_after_rst"));
        applyStimulus(mkRd(ADDR_MASK,       32'h0000_0000, "f_mask_after_rst"));
        checkOutput("f_post_rst_intr", 32'(INTR_A_N), 32'd1);

        repeat (4) tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpci_intr_ctrl.md
Name: cpci_intr_ctrl

Overview:
Interrupt status/mask controller on the CPCI FPGA that drives the active-low PCI INTA line consumed by the host driver.
- Collects event pulses and level conditions from the DMA engine, CNET interface and PHY logic into a 32-bit status register.
- Applies a host-programmed mask and a post-read holdoff.
- Serves the host's CPCI_INTERRUPT_STATUS and CPCI_INTERRUPT_MASK accesses over the internal register bus.

Parameters:
- HOLDOFF_CYCLES, 4: cycles INTR_A_N is forced high after a clearing STATUS read; 0 disables holdoff.
- MASK_RESET, 32'h0000_0000: reset value of the mask register (1 = masked).

Ports:
- CLK  in  1  core/PCI clock.
- RST_N  in  1  synchronous active-low reset.
- reg_rd_req  in  1  single-cycle read request.
- reg_wr_req  in  1  single-cycle write request.
- reg_addr  in  2  0=STATUS (read-clear), 1=MASK (R/W), 2=STATUS_RAW (read, no clear), 3=FORCE (write-1-to-set).
- reg_wr_data  in  32  write data.
- reg_rd_data  out  32  read data, valid when reg_ack=1.
- reg_ack  out  1  one-cycle acknowledge.
- ev_ingress_done, ev_egress_done  in  1 each  pulse events, status bits 31 and 30.
- ev_cnet_err, ev_cnet_rd_timeout, ev_cnet_prog_err  in  1 each  pulses, bits 5, 4, 3.
- ev_dma_timeout, ev_dma_xfer_err, ev_dma_fatal  in  1 each  pulses, bits 2, 1, 0.
- lvl_phy_int  in  1  level, bit 29.
- lvl_pkt_avail  in  1  level, bit 8.
- INTR_A_N  out  1  registered PCI interrupt, active low.

Behaviour:
- Reset (RST_N=0 at a CLK edge): sticky status=0, mask=MASK_RESET, holdoff counter=0, INTR_A_N=1, reg_ack=0, reg_rd_data=0.
- Sticky bits are 31, 30, 5..0.
  - A pulse at edge N sets the bit at N+1.
  - Pulses on consecutive cycles are not counted; the bit just stays set.
- Level bits 29 and 8 are registered copies of the inputs, updated every cycle. Reads never clear them.
- All other bits are reserved, always read 0 and are never set by FORCE. MASK stores all 32 bits.
- Effective status = {sticky | level}; pending = effective & ~mask.
- INTR_A_N at edge N+1 = ~(|pending at N) when the holdoff counter is 0, else 1.
  - End-to-end latency is 2 cycles (event pulse to INTR_A_N low).
- Register access:
  - A request at edge N produces reg_ack=1 and reg_rd_data at N+1. reg_rd_data holds until the next read.
  - Back-to-back requests on every cycle are legal.
  - If reg_rd_req and reg_wr_req are high together, the write wins: one ack, reg_rd_data unchanged.
  - A write to STATUS or STATUS_RAW is acked and ignored.
- STATUS read:
  - The returned value is the effective status at the request edge.
  - The sticky bits captured in that value are cleared.
  - Any event arriving in the same cycle survives (set wins): sticky_next = (sticky & ~captured) | events.
  - The holdoff counter is loaded with HOLDOFF_CYCLES.
- Holdoff counter decrements to 0 and saturates there.
  - A new STATUS read during holdoff reloads it.
  - Holdoff never loses status; it only delays INTR_A_N.
- STATUS_RAW read: same value as STATUS, no clear, no holdoff load.
- MASK write takes effect on pending in the following cycle. MASK read returns the current mask.
- FORCE write: sticky |= wr_data & sticky-bit-mask, plus the same cycle's events.
- Reset asserted mid-access drops the ack and clears everything, as at reset. No partial clear persists.

Decomposition:
- Package cpci_intr_defines holds:
  - bit-index constants INTR_INGRESS_DONE=31, INTR_EGRESS_DONE=30, INTR_PHY=29, INTR_PKT_AVAIL=8, INTR_CNET_ERR=5, INTR_CNET_RD_TIMEOUT=4, INTR_CNET_PROG_ERR=3, INTR_DMA_TIMEOUT=2, INTR_DMA_XFER_ERR=1, INTR_DMA_FATAL=0;
  - STICKY_MASK=32'hC000_003F;
  - LEVEL_MASK=32'h2000_0100;
  - the four register address constants.
- One sub-module, cpci_intr_holdoff: loadable down-counter with a busy output.

Test Plan:
- Reset, then read MASK -> 0x00000000. Read STATUS -> 0x00000000. INTR_A_N=1 throughout.
- Pulse ev_ingress_done at cycle N -> INTR_A_N=0 at N+2. STATUS read -> 0x80000000. Next STATUS_RAW -> 0. INTR_A_N=1 through holdoff (4 cycles) and after.
- Write MASK=0x00000100, then hold lvl_pkt_avail=1 -> INTR_A_N stays 1. STATUS -> 0x00000100. Write MASK=0 -> INTR_A_N=0 two cycles later. A STATUS read does not clear bit 8.
- Pulse ev_dma_fatal in the same cycle as a STATUS read that captures bit 31 -> returned 0x80000000. Following read -> 0x00000001.
- Pulse ev_egress_done during holdoff -> INTR_A_N stays 1 until holdoff expires, then goes 0. The bit reads back set.
- Write FORCE=0xFFFFFFFF -> STATUS_RAW=0xC000003F (levels low). Simultaneous rd+wr to MASK -> single ack, mask updated.
